// File: rtl/mips_fetch_prefetch_if.sv
// Fetch-unit bundle: memory request/response channels plus the core-side
// instruction and redirect signals. The fetch unit is the master.
interface mips_fetch_prefetch_if;
    // Memory request channel
    logic [31:0] if_req_addr;
    logic        if_req_valid;
    logic        if_req_ack;
    // Memory response channel
    logic [31:0] if_rsp_data;
    logic        if_rsp_valid;
    logic        if_rsp_ack;
    // Core-side instruction stream
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    // Control-flow redirect from the core
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output if_req_addr,
        output if_req_valid,
        input  if_req_ack,
        input  if_rsp_data,
        input  if_rsp_valid,
        output if_rsp_ack,
        output inst_valid,
        output inst_pc,
        output inst_data,
        input  inst_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  if_req_addr,
        input  if_req_valid,
        output if_req_ack,
        output if_rsp_data,
        output if_rsp_valid,
        input  if_rsp_ack,
        input  inst_valid,
        input  inst_pc,
        input  inst_data,
        output inst_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/mips_fetch_prefetch.sv
// Instruction-fetch front end: issues one outstanding sequential fetch at a time,
// buffers returned words in a circular prefetch queue and presents {pc, inst} to the
// core. A redirect flushes the queue and discards any response still in flight.
module mips_fetch_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_fetch_prefetch_if.master    bus_io,
    output logic [$clog2(DEPTH):0]   pf_count_o,
    output logic [CNT_W-1:0]         perf_fetch_o,
    output logic [CNT_W-1:0]         perf_drop_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRsp  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             discard_q, discard_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [31:0]      q_pc_q   [DEPTH];
    logic [31:0]      q_data_q [DEPTH];
    logic [31:0]      last_pc_q, last_data_q;
    logic [CNT_W-1:0] perf_fetch_q, perf_drop_q;

    logic             head_valid;
    logic             push, pop, drop;
    logic [31:0]      redirect_pc_al;

    assign redirect_pc_al = bus_io.redirect_pc & ~32'h3;
    assign head_valid     = (count_q != '0);

    // Bus outputs decode directly from registered state
    assign bus_io.if_req_valid = (state_q == StReq);
    assign bus_io.if_rsp_ack   = (state_q == StRsp);
    assign bus_io.if_req_addr  = req_addr_q;

    // When empty the head shows the last word handed to the core
    assign bus_io.inst_valid = head_valid;
    assign bus_io.inst_pc    = head_valid ? q_pc_q[rd_ptr_q]   : last_pc_q;
    assign bus_io.inst_data  = head_valid ? q_data_q[rd_ptr_q] : last_data_q;

    assign pf_count_o   = count_q;
    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;

    // Fetch FSM, redirect handling and queue occupancy
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        drop       = 1'b0;

        case (state_q)
            StIdle: begin
            end
            StReq: begin
                if (bus_io.if_req_ack) begin
                    state_d = StRsp;
                    // After a redirect fetch_pc already holds the new target
                    if (!discard_q) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            StRsp: begin
                if (bus_io.if_rsp_valid) begin
                    state_d = StIdle;
                    if (discard_q || bus_io.redirect) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    discard_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus_io.redirect) begin
            fetch_pc_d = redirect_pc_al;
            // An outstanding request's word must be thrown away when it arrives
            if ((state_q == StReq) || ((state_q == StRsp) && !bus_io.if_rsp_valid)) begin
                discard_d = 1'b1;
            end
        end

        pop = head_valid && bus_io.inst_ready && !bus_io.redirect;

        if (bus_io.redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
        end

        // Issue only while a slot remains for the word that will come back
        if ((state_d == StIdle) && (count_d < DepthC)) begin
            state_d    = StReq;
            req_addr_d = fetch_pc_d;
        end
    end

    // Queue pointers; a redirect restarts them from zero
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus_io.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Control and counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_addr_q   <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            discard_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            fetch_pc_q   <= fetch_pc_d;
            discard_q    <= discard_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            perf_fetch_q <= perf_fetch_q + CNT_W'(pop);
            perf_drop_q  <= perf_drop_q + CNT_W'(drop);
        end
    end

    // Queue storage; the word is tagged with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]   <= req_addr_q;
            q_data_q[wr_ptr_q] <= bus_io.if_rsp_data;
        end
    end

    // Remember the most recently consumed word for display while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q   <= '0;
            last_data_q <= '0;
        end else if (pop) begin
            last_pc_q   <= q_pc_q[rd_ptr_q];
            last_data_q <= q_data_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_mips_fetch_prefetch.sv
// Directed bench for mips_fetch_prefetch with a small memory responder.
// Memory returns ~addr as the instruction word, one cycle after the request ack.
module tb_mips_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pf_count;
    logic [31:0] perf_fetch;
    logic [31:0] perf_drop;

    int checks   = 0;
    int failures = 0;

    logic        ack_en;
    logic        rsp_en;
    logic        rsp_pend;
    logic [31:0] rsp_addr;
    int          hs_cnt;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];

    mips_fetch_prefetch_if bus();

    mips_fetch_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_io       (bus),
        .pf_count_o   (pf_count),
        .perf_fetch_o (perf_fetch),
        .perf_drop_o  (perf_drop)
    );

    always #5 clk = ~clk;

    // Memory drives its inputs shortly after the falling edge
    always @(negedge clk) begin
        #1;
        bus.if_req_ack   = ack_en && bus.if_req_valid;
        bus.if_rsp_valid = rsp_pend && rsp_en;
        bus.if_rsp_data  = ~rsp_addr;
    end

    // Memory bookkeeping of accepted requests
    always @(posedge clk) begin
        if (rst) begin
            rsp_pend <= 1'b0;
            rsp_addr <= 32'h0;
            hs_cnt   <= 0;
        end else if (bus.if_req_valid && bus.if_req_ack) begin
            rsp_pend <= 1'b1;
            rsp_addr <= bus.if_req_addr;
            hs_cnt   <= hs_cnt + 1;
        end else if (bus.if_rsp_valid && bus.if_rsp_ack) begin
            rsp_pend <= 1'b0;
        end
    end

    // Log every word the core consumes
    always @(posedge clk) begin
        if (rst) begin
            pop_pc.delete();
            pop_data.delete();
        end else if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            pop_pc.push_back(bus.inst_pc);
            pop_data.push_back(bus.inst_data);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Returns on the falling edge at which rst is released
    task automatic do_reset(input logic rdy, input logic a_en, input logic r_en);
        step();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = rdy;
        ack_en          = a_en;
        rsp_en          = r_en;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        ack_en          = 1'b1;
        rsp_en          = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.if_req_valid !== 1'b0) begin failures++;
            $display("FAIL rst_req_valid: got %b want 0", bus.if_req_valid); end
        checks++; if (bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL rst_req_addr: got %h want 00000000", bus.if_req_addr); end
        checks++; if (bus.if_rsp_ack !== 1'b0) begin failures++;
            $display("FAIL rst_rsp_ack: got %b want 0", bus.if_rsp_ack); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++;
            $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
        checks++; if (pf_count !== 3'd0) begin failures++;
            $display("FAIL rst_pf_count: got %0d want 0", pf_count); end
        checks++; if (perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin failures++;
            $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch, perf_drop); end
        bus.inst_ready = 1'b1;
        rst            = 1'b0;
        step();
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL first_req: got v=%b a=%h want v=1 a=00000000",
                     bus.if_req_valid, bus.if_req_addr); end
    endtask

    // Zero-wait memory with ready core: one word every two cycles
    task automatic test_stream();
        int cyc;
        cyc = 1;
        while (pop_pc.size() < 6 && cyc < 40) begin
            step();
            cyc++;
        end
        checks++; if (cyc !== 14) begin failures++;
            $display("FAIL stream_rate: sixth pop at cycle %0d want 14", cyc); end
        checks++; if (pop_pc.size() < 6) begin failures++;
            $display("FAIL stream_count: got %0d pops want 6", pop_pc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (pop_pc[i] !== 32'(i * 4)) begin failures++;
                    $display("FAIL stream_pc[%0d]: got %h want %h", i, pop_pc[i], 32'(i * 4)); end
                checks++; if (pop_data[i] !== ~32'(i * 4)) begin failures++;
                    $display("FAIL stream_data[%0d]: got %h want %h", i, pop_data[i],
                             ~32'(i * 4)); end
            end
        end
        checks++; if (perf_fetch !== 32'd6) begin failures++;
            $display("FAIL stream_perf_fetch: got %0d want 6", perf_fetch); end
    endtask

    // Core stalled: queue fills to DEPTH and fetching stops, then drains in order
    task automatic test_backpressure();
        logic [31:0] exp_pc [6];
        int cyc;
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14};
        do_reset(1'b0, 1'b1, 1'b1);
        repeat (20) step();
        checks++; if (pf_count !== 3'd4) begin failures++;
            $display("FAIL full_count: got %0d want 4", pf_count); end
        checks++; if (bus.if_req_valid !== 1'b0) begin failures++;
            $display("FAIL full_req_valid: got %b want 0", bus.if_req_valid); end
        checks++; if (hs_cnt !== 4) begin failures++;
            $display("FAIL full_handshakes: got %0d want 4", hs_cnt); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 ||
                      bus.inst_data !== 32'hffffffff) begin failures++;
            $display("FAIL full_head: got v=%b pc=%h d=%h want v=1 pc=00000000 d=ffffffff",
                     bus.inst_valid, bus.inst_pc, bus.inst_data); end
        bus.inst_ready = 1'b1;
        cyc = 0;
        while (pop_pc.size() < 6 && cyc < 40) begin
            step();
            cyc++;
        end
        checks++; if (pop_pc.size() < 6) begin failures++;
            $display("FAIL drain_count: got %0d pops want 6", pop_pc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (pop_pc[i] !== exp_pc[i]) begin failures++;
                    $display("FAIL drain_pc[%0d]: got %h want %h", i, pop_pc[i], exp_pc[i]); end
            end
        end
    endtask

    // Memory withholds ack: request must hold steady and handshake exactly once
    task automatic test_ack_stall();
        do_reset(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b a=%h want v=1 a=00000000",
                         i, bus.if_req_valid, bus.if_req_addr); end
        end
        ack_en = 1'b1;
        step();
        checks++; if (hs_cnt !== 1 || bus.if_rsp_ack !== 1'b1) begin failures++;
            $display("FAIL stall_ack: got hs=%0d rsp_ack=%b want hs=1 rsp_ack=1",
                     hs_cnt, bus.if_rsp_ack); end
        ack_en = 1'b0;
        step();
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h4) begin failures++;
            $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=00000004",
                     bus.if_req_valid, bus.if_req_addr); end
        checks++; if (hs_cnt !== 1) begin failures++;
            $display("FAIL stall_single_hs: got %0d want 1", hs_cnt); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin failures++;
            $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=00000000",
                     bus.inst_valid, bus.inst_pc); end
    endtask

    // Redirect while waiting for a response: flush, drop late word, refetch target
    task automatic test_redirect_rsp();
        int cyc;
        do_reset(1'b0, 1'b1, 1'b1);
        repeat (5) step();
        rsp_en = 1'b0;
        step();
        checks++; if (pf_count !== 3'd2 || bus.if_rsp_ack !== 1'b1) begin failures++;
            $display("FAIL rdr_rsp_pre: got cnt=%0d rsp_ack=%b want cnt=2 rsp_ack=1",
                     pf_count, bus.if_rsp_ack); end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h1003;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || pf_count !== 3'd0) begin failures++;
            $display("FAIL rdr_rsp_flush: got v=%b cnt=%0d want v=0 cnt=0",
                     bus.inst_valid, pf_count); end
        checks++; if (bus.if_rsp_ack !== 1'b1) begin failures++;
            $display("FAIL rdr_rsp_still_ack: got %b want 1", bus.if_rsp_ack); end
        rsp_en = 1'b1;
        step();
        checks++; if (perf_drop !== 32'd1) begin failures++;
            $display("FAIL rdr_rsp_drop: got %0d want 1", perf_drop); end
        checks++; if (pf_count !== 3'd0 || perf_fetch !== 32'd0) begin failures++;
            $display("FAIL rdr_rsp_nopush: got cnt=%0d fetch=%0d want 0/0",
                     pf_count, perf_fetch); end
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h1000) begin
            failures++;
            $display("FAIL rdr_rsp_newreq: got v=%b a=%h want v=1 a=00001000",
                     bus.if_req_valid, bus.if_req_addr); end
        bus.inst_ready = 1'b1;
        cyc = 0;
        while (pop_pc.size() < 1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++; if (pop_pc.size() < 1) begin failures++;
            $display("FAIL rdr_rsp_resume: got 0 pops want 1");
        end else begin
            checks++; if (pop_pc[0] !== 32'h1000 || pop_data[0] !== 32'hffffefff) begin
                failures++;
                $display("FAIL rdr_rsp_word: got pc=%h d=%h want pc=00001000 d=ffffefff",
                         pop_pc[0], pop_data[0]); end
        end
    endtask

    // Redirect before ack: old request completes untouched, its word is discarded
    task automatic test_redirect_req();
        do_reset(1'b0, 1'b0, 1'b1);
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h2000;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL rdr_req_hold: got v=%b a=%h want v=1 a=00000000",
                     bus.if_req_valid, bus.if_req_addr); end
        ack_en = 1'b1;
        step();
        checks++; if (hs_cnt !== 1 || bus.if_rsp_ack !== 1'b1) begin failures++;
            $display("FAIL rdr_req_ack: got hs=%0d rsp_ack=%b want hs=1 rsp_ack=1",
                     hs_cnt, bus.if_rsp_ack); end
        step();
        checks++; if (perf_drop !== 32'd1 || pf_count !== 3'd0) begin failures++;
            $display("FAIL rdr_req_drop: got drop=%0d cnt=%0d want drop=1 cnt=0",
                     perf_drop, pf_count); end
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h2000) begin
            failures++;
            $display("FAIL rdr_req_newreq: got v=%b a=%h want v=1 a=00002000",
                     bus.if_req_valid, bus.if_req_addr); end
        step();
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h2000) begin failures++;
            $display("FAIL rdr_req_head: got v=%b pc=%h want v=1 pc=00002000",
                     bus.inst_valid, bus.inst_pc); end
    endtask

    // PC wraps past the top of memory; reset in the middle of a response
    task automatic test_wrap_and_reset();
        do_reset(1'b0, 1'b0, 1'b1);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hfffffffc;
        step();
        bus.redirect = 1'b0;
        ack_en       = 1'b1;
        step();
        step();
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'hfffffffc) begin
            failures++;
            $display("FAIL wrap_top_req: got v=%b a=%h want v=1 a=fffffffc",
                     bus.if_req_valid, bus.if_req_addr); end
        step();
        step();
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL wrap_zero_req: got v=%b a=%h want v=1 a=00000000",
                     bus.if_req_valid, bus.if_req_addr); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hfffffffc) begin
            failures++;
            $display("FAIL wrap_head: got v=%b pc=%h want v=1 pc=fffffffc",
                     bus.inst_valid, bus.inst_pc); end
        rsp_en = 1'b0;
        step();
        checks++; if (bus.if_rsp_ack !== 1'b1 || pf_count !== 3'd1 || perf_drop !== 32'd1)
        begin failures++;
            $display("FAIL wrap_pre_rst: got rsp_ack=%b cnt=%0d drop=%0d want 1/1/1",
                     bus.if_rsp_ack, pf_count, perf_drop); end
        rst = 1'b1;
        step();
        checks++; if (pf_count !== 3'd0 || bus.inst_valid !== 1'b0) begin failures++;
            $display("FAIL mid_rst_queue: got cnt=%0d v=%b want cnt=0 v=0",
                     pf_count, bus.inst_valid); end
        checks++; if (perf_drop !== 32'd0 || perf_fetch !== 32'd0) begin failures++;
            $display("FAIL mid_rst_perf: got %0d/%0d want 0/0", perf_fetch, perf_drop); end
        checks++; if (bus.if_rsp_ack !== 1'b0 || bus.if_req_valid !== 1'b0 ||
                      bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL mid_rst_bus: got rsp_ack=%b v=%b a=%h want 0/0/00000000",
                     bus.if_rsp_ack, bus.if_req_valid, bus.if_req_addr); end
        rst    = 1'b0;
        rsp_en = 1'b1;
        step();
        checks++; if (bus.if_req_valid !== 1'b1 || bus.if_req_addr !== 32'h0) begin failures++;
            $display("FAIL mid_rst_resume: got v=%b a=%h want v=1 a=00000000",
                     bus.if_req_valid, bus.if_req_addr); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_ack_stall();
        test_redirect_rsp();
        test_redirect_req();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
